freq_div_prog: RTL and testbench
================================

Name: freq_div_prog

Overview:
- Runtime-programmable clock divider; successor to the fixed divide-by-100 divider.
- Produces a near-50%-duty divided clock (`clk_div`) and a one-cycle `tick` strobe from `clk_ref`.
- Divisor is parametrised in width and reloadable at run time; new values take effect only at a period boundary, so the output never glitches.
- Feeds the slow-timing logic: scan refresh, debounce sampling, timers.

Parameters:
- CNT_W, 16, counter and divisor width in bits.
- DEFAULT_DIV, 100, divisor in force after reset; must satisfy 2 <= DEFAULT_DIV < 2^CNT_W.

Ports:
- clk_ref  in  1  reference clock; all logic on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  count enable.
- div_val  in  CNT_W  new divisor N.
- div_load  in  1  one-cycle strobe; captures div_val.
- clk_div  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse at each period start, registered.
- pending  out  1  a loaded divisor is waiting for the next boundary.

Behaviour:
- Reset (rst=1 at an edge):
  - active divisor N <= DEFAULT_DIV; count <= N-1.
  - clk_div <= 0; tick <= 0; pending <= 0.
- Counting (en=1): count <= (count==N-1) ? 0 : count+1.
- Output definitions, with next = the post-update count value and H = ceil(N/2) = (N+1)>>1:
  - clk_div <= (next < H).
  - tick <= (next == 0).
- Timing consequences:
  - First enabled edge after reset: count=0, clk_div=1, tick=1. The first period is clean; latency is 1 clk_ref cycle.
  - Period is N cycles: high H cycles, low N-H cycles (N=7: 4 high / 3 low).
- Divisor load:
  - On div_load=1, div_val is captured into a pending register and pending <= 1. Values below 2 are clamped to 2.
  - Repeated loads before the boundary: last one wins.
  - Applied on the wrap edge (count==N-1, en=1): N <= pending value, pending <= 0. The new period starts from count 0 with the new H.
  - div_load on the wrap edge itself: div_val takes effect at that same wrap, bypassing the pending register; pending stays 0.
  - div_load while en=0: the value is applied at the next edge. N <= value, count <= value-1, clk_div <= 0, pending <= 0. The next enabled edge therefore starts a clean period.
- en=0:
  - count and clk_div hold; tick <= 0.
  - Resuming continues mid-period with no phase loss.
- Reset mid-period overrides everything, including an in-flight pending load, which is discarded.
- Arithmetic: all comparisons are unsigned CNT_W-bit. Maximum N is 2^CNT_W-1; count never exceeds N-1.

Optional Feature:
- Macro: FREQ_DIV_SYNC_EN.
- Defined: adds input port sync_in (1 bit).
  - sync_in=1 at an edge with en=1 forces next=0, giving clk_div=1 and tick=1. Any pending divisor is applied at that edge.
  - Used to phase-align several dividers.
  - Priority: rst > sync_in > normal counting.
  - sync_in while en=0 is ignored.
- Undefined: the port and its logic are absent; behaviour is exactly as above.

Decomposition:
- Package freq_div_pkg:
  - CNT_W default.
  - MIN_DIV=2.
  - Function high_len(N) returning (N+1)>>1.
  - Clamp function for divisor values.
- Sub-module freq_div_core:
  - Contains the counter, compare and registered outputs, given a stable N.
  - The top level freq_div_prog holds the pending register, clamp, load/boundary control and the optional sync.

Test Plan:
- Reset, en=1, N=100 → tick every 100 cycles; clk_div 50 high / 50 low; first tick 1 cycle after rst release.
- div_load with div_val=7 while en=0, then en=1 → clk_div 4 high / 3 low repeating; tick every 7 cycles.
- N=100, div_load div_val=10 at count 40 → pending=1 until the count-99 edge; next period is 10 cycles (5/5); no short pulse on clk_div.
- div_val=1 and div_val=0 → clamped to 2: clk_div alternates 1/0 each cycle; tick every 2 cycles.
- en dropped at count 30 for 20 cycles → clk_div and count frozen, tick=0; after resume the period completes 70 cycles later.
- rst asserted mid-period with pending=1 → next edge: clk_div=0, pending=0, N=DEFAULT_DIV. With FREQ_DIV_SYNC_EN: sync_in at count 55 → next edge tick=1, clk_div=1.

Source files
------------

// File: rtl/freq_div_pkg.sv
// Shared constants and helpers for the programmable clock divider.
package freq_div_pkg;

    localparam int          CNT_W_DEF = 16;
    localparam logic [31:0] MIN_DIV   = 32'd2;

    // High-phase length of an N-cycle period: ceil(N/2), computed one bit wider so N = 2^32-1 cannot wrap.
    function automatic logic [31:0] high_len(input logic [31:0] n);
        logic [32:0] sum;
        sum = {1'b0, n} + 33'd1;
        return sum[32:1];
    endfunction

    function automatic logic [31:0] clamp_div(input logic [31:0] n);
        return (n < MIN_DIV) ? MIN_DIV : n;
    endfunction

endpackage

// File: rtl/freq_div_core.sv
// Divider counter with registered clk_div/tick outputs; the caller supplies the divisor in force
// now (for wrap detection) and the divisor for the period being entered (for the high phase).
module freq_div_core
    import freq_div_pkg::*;
#(
    parameter int               CNT_W     = CNT_W_DEF,
    parameter logic [CNT_W-1:0] DEFAULT_N = CNT_W'(100)
) (
    input  logic             clk_ref_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             restart_i,
    input  logic             reload_i,
    input  logic [CNT_W-1:0] n_cur_i,
    input  logic [CNT_W-1:0] n_nxt_i,
    output logic             boundary_o,
    output logic             clk_div_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] next_cnt;
    logic [CNT_W-1:0] high_n;
    logic             clk_div_q, clk_div_d;
    logic             tick_q, tick_d;

    assign boundary_o = en_i && (restart_i || (count_q == n_cur_i - ONE));
    assign next_cnt   = boundary_o ? '0 : count_q + ONE;
    assign high_n     = CNT_W'(high_len(32'(n_nxt_i)));

    always_comb begin
        // NOTE: every variable gets its default before any branch, otherwise an unassigned path infers a latch.
        count_d   = count_q;
        clk_div_d = clk_div_q;
        tick_d    = 1'b0;
        if (en_i) begin
            count_d   = next_cnt;
            clk_div_d = (next_cnt < high_n);
            tick_d    = (next_cnt == '0);
        end else if (reload_i) begin
            // Parking at N-1 with clk_div low makes the next enabled edge a clean period start.
            count_d   = n_nxt_i - ONE;
            clk_div_d = 1'b0;
        end
    end

    // NOTE: registers use <= so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            count_q   <= DEFAULT_N - ONE;
            clk_div_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            clk_div_q <= clk_div_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_div_o = clk_div_q;
    assign tick_o    = tick_q;

endmodule

// File: rtl/freq_div_prog.sv
// Runtime-programmable clock divider: pending-divisor register, clamp and boundary control.
// Optional phase-align input sync_in is built when FREQ_DIV_SYNC_EN is defined.
module freq_div_prog
    import freq_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = 100
) (
    input  logic             clk_ref,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_val,
    input  logic             div_load,
`ifdef FREQ_DIV_SYNC_EN
    input  logic             sync_in,
`endif
    output logic             clk_div,
    output logic             tick,
    output logic             pending
);

    localparam logic [CNT_W-1:0] DEFAULT_N = CNT_W'(DEFAULT_DIV);

    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] load_val;
    logic             sync_w;
    logic             boundary;

`ifdef FREQ_DIV_SYNC_EN
    assign sync_w = sync_in;
`else
    assign sync_w = 1'b0;
`endif

    assign load_val = CNT_W'(clamp_div(32'(div_val)));

    always_comb begin
        n_d        = n_q;
        pend_d     = pend_q;
        pend_val_d = pend_val_q;
        if (en) begin
            if (boundary) begin
                // A load arriving on the boundary edge itself wins over anything already pending.
                if (div_load) begin
                    n_d = load_val;
                end else if (pend_q) begin
                    n_d = pend_val_q;
                end
                pend_d = 1'b0;
            end else if (div_load) begin
                pend_val_d = load_val;
                pend_d     = 1'b1;
            end
        end else if (div_load) begin
            n_d    = load_val;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (rst) begin
            n_q        <= DEFAULT_N;
            pend_q     <= 1'b0;
            pend_val_q <= DEFAULT_N;
        end else begin
            n_q        <= n_d;
            pend_q     <= pend_d;
            pend_val_q <= pend_val_d;
        end
    end

    freq_div_core #(
        .CNT_W     (CNT_W),
        .DEFAULT_N (DEFAULT_N)
    ) u_core (
        .clk_ref_i  (clk_ref),
        .rst_i      (rst),
        .en_i       (en),
        .restart_i  (sync_w),
        .reload_i   (div_load && !en),
        .n_cur_i    (n_q),
        .n_nxt_i    (n_d),
        .boundary_o (boundary),
        .clk_div_o  (clk_div),
        .tick_o     (tick)
    );

    assign pending = pend_q;

endmodule

// File: tb/tb_freq_div_prog.sv
// Self-checking bench for freq_div_prog: cycle scoreboard fed by a behavioural model plus period measurements.
module tb_freq_div_prog;

    localparam int CNT_W   = 16;
    localparam int DEF_DIV = 100;

    logic             clk_ref = 1'b0;
    logic             rst;
    logic             en;
    logic             div_load;
    logic             sync_in;
    logic [CNT_W-1:0] div_val;
    logic             clk_div;
    logic             tick;
    logic             pending;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [2:0] exp_q[$];

    int m_n, m_cnt, m_pval;
    bit m_pend, m_div, m_tick;

    always #5 clk_ref = ~clk_ref;

    freq_div_prog #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk_ref  (clk_ref),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
`ifdef FREQ_DIV_SYNC_EN
        .sync_in  (sync_in),
`endif
        .clk_div  (clk_div),
        .tick     (tick),
        .pending  (pending)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: predicts {clk_div, tick, pending} after the coming edge.
    task automatic model_step();
        int lv;
        lv = (int'(div_val) < 2) ? 2 : int'(div_val);
        if (rst) begin
            m_n = DEF_DIV; m_cnt = DEF_DIV - 1; m_div = 0; m_tick = 0; m_pend = 0;
        end else if (en) begin
            if (sync_in || m_cnt == m_n - 1) begin
                if (div_load)    m_n = lv;
                else if (m_pend) m_n = m_pval;
                m_pend = 0;
                m_cnt  = 0;
            end else begin
                m_cnt++;
                if (div_load) begin
                    m_pval = lv;
                    m_pend = 1;
                end
            end
            m_div  = (m_cnt < (m_n + 1) / 2);
            m_tick = (m_cnt == 0);
        end else begin
            m_tick = 0;
            if (div_load) begin
                m_n = lv; m_cnt = lv - 1; m_div = 0; m_pend = 0;
            end
        end
        exp_q.push_back({m_div, m_tick, m_pend});
    endtask

    task automatic cycle();
        logic [2:0] exp;
        model_step();
        @(posedge clk_ref);
        #1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            check("cyc", {29'd0, clk_div, tick, pending}, {29'd0, exp});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Expects the next edge to start a period of n cycles with exp_high high cycles and a single tick.
    task automatic measure_period(input string tag, input int n, input int exp_high);
        int highs, ticks;
        bit first_tick;
        highs = 0; ticks = 0; first_tick = 0;
        for (int i = 0; i < n; i++) begin
            cycle();
            if (clk_div) highs++;
            if (tick)    ticks++;
            if (i == 0)  first_tick = tick;
        end
        check({tag, "_first_tick"}, 32'(first_tick), 32'd1);
        check({tag, "_high"},       32'(highs),      32'(exp_high));
        check({tag, "_ticks"},      32'(ticks),      32'd1);
    endtask

    task automatic load_once(input int val);
        div_load = 1'b1;
        div_val  = CNT_W'(val);
        cycle();
        div_load = 1'b0;
        div_val  = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int ticks, highs, changes;
        logic held;
        rst = 1'b1; en = 1'b0; div_load = 1'b0; sync_in = 1'b0; div_val = '0;
        run(2);
        check("rst_out", {29'd0, clk_div, tick, pending}, 32'd0);

        // Default divisor: first tick one cycle after release, 50/50 duty.
        rst = 1'b0; en = 1'b1;
        measure_period("n100_a", 100, 50);
        measure_period("n100_b", 100, 50);

        // Mid-period reload to 10, held pending until the count-99 edge.
        run(41);
        load_once(10);
        check("pend_set10", 32'(pending), 32'd1);
        run(58);
        check("pend_hold10", 32'(pending), 32'd1);
        measure_period("n10_a", 10, 5);
        check("pend_clr10", 32'(pending), 32'd0);
        measure_period("n10_b", 10, 5);

        // Load while disabled: applied at once, clean start on enable.
        en = 1'b0;
        load_once(7);
        check("idle_load7", {29'd0, clk_div, tick, pending}, 32'd0);
        en = 1'b1;
        measure_period("n7_a", 7, 4);
        measure_period("n7_b", 7, 4);

        // Load of 0 on the wrap edge: clamped to 2 and applied immediately.
        load_once(0);
        check("bypass_tick", {29'd0, clk_div, tick, pending}, 32'b110);
        cycle();
        check("clamp0_low", 32'(clk_div), 32'd0);
        measure_period("clamp0", 2, 1);

        // Load of 1 while disabled: clamped to 2.
        en = 1'b0;
        load_once(1);
        en = 1'b1;
        measure_period("clamp1_a", 2, 1);
        measure_period("clamp1_b", 2, 1);

        // Pause at count 30 for 20 cycles, then finish the period.
        en = 1'b0;
        load_once(100);
        en = 1'b1;
        run(31);
        held = clk_div;
        check("pre_pause_high", 32'(held), 32'd1);
        en = 1'b0;
        ticks = 0; changes = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (tick) ticks++;
            if (clk_div !== held) changes++;
        end
        check("pause_tick", 32'(ticks), 32'd0);
        check("pause_hold", 32'(changes), 32'd0);
        en = 1'b1;
        ticks = 0; highs = 0;
        for (int i = 0; i < 69; i++) begin
            cycle();
            if (tick)    ticks++;
            if (clk_div) highs++;
        end
        check("resume_ticks", 32'(ticks), 32'd0);
        check("resume_high", 32'(highs), 32'd19);
        cycle();
        check("resume_wrap", 32'(tick), 32'd1);

        // Reset mid-period discards a pending load.
        run(10);
        load_once(5);
        check("pend_set5", 32'(pending), 32'd1);
        run(5);
        rst = 1'b1;
        cycle();
        check("rst_mid", {29'd0, clk_div, tick, pending}, 32'd0);
        rst = 1'b0;
        measure_period("after_rst", 100, 50);

`ifdef FREQ_DIV_SYNC_EN
        // Sync at count 55 restarts the period and applies the pending divisor.
        run(20);
        load_once(10);
        run(35);
        sync_in = 1'b1;
        cycle();
        sync_in = 1'b0;
        check("sync_restart", {29'd0, clk_div, tick, pending}, 32'b110);
        highs = 0;
        for (int i = 0; i < 9; i++) begin
            cycle();
            if (clk_div) highs++;
        end
        check("sync_high", 32'(highs), 32'd4);
        measure_period("sync_n10", 10, 5);
        en = 1'b0;
        sync_in = 1'b1;
        cycle();
        sync_in = 1'b0;
        check("sync_idle", 32'(tick), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
